stopwatch_lap_ctrl: RTL and testbench

Second-generation stopwatch controller: run/pause/clear state machine plus an integrated prescaled elapsed-time counter, configurable overflow policy and a lap-capture FIFO. It sits between the synchronised, debounced button pulses and the display/readout logic, replacing the bare control FSM plus external counter enable.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/lap_fifo.sv | 64 ++++++
 rtl/stopwatch_lap_ctrl.sv | 151 +++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch lap controller.
// State/status encodings and lap FIFO width helper.
package stopwatch_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUNNING = 2'b01;
  localparam logic [1:0] PAUSED  = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef logic [1:0] sw_status_t;

  localparam sw_status_t STAT_IDLE    = IDLE;
  localparam sw_status_t STAT_RUNNING = RUNNING;
  localparam sw_status_t STAT_PAUSED  = PAUSED;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous first-word fall-through FIFO.
// Holds captured lap values until read out.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_lvl;
  logic          w_wr;
  logic          w_rd;

  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);
  assign full  = (r_lvl == LW'(DEPTH));
  assign empty = (r_lvl == '0);
  assign level = r_lvl;
  assign dout  = r_mem[r_rp];

  // Pointer, level and storage update; clr empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
      r_mem <= '{default: '0};
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch run/pause/clear control with prescaled
// elapsed counter, overflow policy and lap capture.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 1000,
  parameter int WRAP      = 1,
  parameter int LAP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        reset,
  input  logic                        lap,
  input  logic                        lap_rd,
  output logic                        enable,
  output logic [1:0]                  status,
  output logic                        tick,
  output logic [CNT_W-1:0]            count,
  output logic                        overflow,
  output logic [CNT_W-1:0]            lap_data,
  output logic                        lap_valid,
  output logic [lvl_w(LAP_DEPTH)-1:0] lap_level,
  output logic                        lap_drop
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_nxt;
  logic [PW-1:0]    r_pre;
  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_ovf;
  logic             r_drop;
  logic             w_run;
  logic             w_period;
  logic             w_at_max;
  logic             w_sat;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_run    = (r_state == RUNNING);
  assign w_period = w_run && (r_pre == PRE_LAST);
  assign w_at_max = (r_count == CNT_MAX);
  assign w_sat    = w_period && w_at_max && (WRAP == 0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next state: reset beats stop beats start.
  always_comb begin
    w_nxt = r_state;
    if (reset) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (start && !stop) w_nxt = RUNNING;
        RUNNING: if (stop || w_sat)  w_nxt = PAUSED;
        PAUSED:  if (start && !stop) w_nxt = RUNNING;
        default: w_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    enable = (r_state == RUNNING);
    status = r_state;
  end

  // Prescaler: runs while RUNNING, held while PAUSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (reset) begin
      r_pre <= '0;
    end else if (w_run) begin
      r_pre <= w_period ? '0 : r_pre + 1'b1;
    end else if (r_state != PAUSED) begin
      r_pre <= '0;
    end
  end

  // Elapsed count, tick pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tick <= w_period;
      if (w_period) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
          if (WRAP != 0) r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign w_push = lap && !reset &&
                  ((r_state == RUNNING) ||
                   (r_state == PAUSED));
  assign w_pop  = lap_rd && !w_empty && !reset;

  // Sticky flag for a lap lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_drop <= 1'b0;
    else if (reset)                       r_drop <= 1'b0;
    else if (w_push && w_full && !w_pop)  r_drop <= 1'b1;
  end

  lap_fifo #(
    .W     (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_count),
    .dout  (lap_data),
    .full  (w_full),
    .empty (w_empty),
    .level (lap_level)
  );

  assign tick      = r_tick;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign lap_valid = !w_empty;
  assign lap_drop  = r_drop;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: wrap and saturate
// instances driven together against a timing model.
module tb_stopwatch_lap_ctrl;

  localparam int P   = 4;
  localparam int MX  = 15;
  localparam int DEP = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic stop;
  logic reset;
  logic lap;
  logic lap_rd;

  logic       o_en   [2];
  logic [1:0] o_st   [2];
  logic       o_tick [2];
  logic [3:0] o_cnt  [2];
  logic       o_ovf  [2];
  logic [3:0] o_ld   [2];
  logic       o_lv   [2];
  logic [2:0] o_ll   [2];
  logic       o_drop [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit en_cmp  = 0;

  stopwatch_lap_ctrl #(
    .CNT_W(4), .PRESCALE(P), .WRAP(1), .LAP_DEPTH(DEP)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .reset(reset), .lap(lap), .lap_rd(lap_rd),
    .enable(o_en[0]), .status(o_st[0]), .tick(o_tick[0]),
    .count(o_cnt[0]), .overflow(o_ovf[0]),
    .lap_data(o_ld[0]), .lap_valid(o_lv[0]),
    .lap_level(o_ll[0]), .lap_drop(o_drop[0])
  );

  stopwatch_lap_ctrl #(
    .CNT_W(4), .PRESCALE(P), .WRAP(0), .LAP_DEPTH(DEP)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .reset(reset), .lap(lap), .lap_rd(lap_rd),
    .enable(o_en[1]), .status(o_st[1]), .tick(o_tick[1]),
    .count(o_cnt[1]), .overflow(o_ovf[1]),
    .lap_data(o_ld[1]), .lap_valid(o_lv[1]),
    .lap_level(o_ll[1]), .lap_drop(o_drop[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 running, 2 paused.
  // act counts clock cycles spent running since clear.
  int m_mode [2] = '{0, 0};
  int m_act  [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  int m_ovf  [2] = '{0, 0};
  int m_drop [2] = '{0, 0};
  int m_tick [2] = '{0, 0};
  int mq     [2][$];

  task automatic m_clear(input int i);
    m_mode[i] = 0;
    m_act[i]  = 0;
    m_cnt[i]  = 0;
    m_ovf[i]  = 0;
    m_drop[i] = 0;
    m_tick[i] = 0;
    mq[i].delete();
  endtask

  task automatic m_edge(input int i, input bit wr);
    int  old;
    bit  sat;
    old = m_cnt[i];
    sat = 0;
    if (reset) begin
      m_clear(i);
      return;
    end
    m_tick[i] = 0;
    if (m_mode[i] == 1) begin
      m_act[i]++;
      if (m_act[i] % P == 0) begin
        m_tick[i] = 1;
        if (old == MX) begin
          m_ovf[i] = 1;
          if (wr) m_cnt[i] = 0;
          else    sat = 1;
        end else begin
          m_cnt[i] = old + 1;
        end
      end
    end
    if (lap_rd && mq[i].size() > 0) void'(mq[i].pop_front());
    if (lap && m_mode[i] != 0) begin
      if (mq[i].size() < DEP) mq[i].push_back(old);
      else                    m_drop[i] = 1;
    end
    if (stop) begin
      if (m_mode[i] == 1) m_mode[i] = 2;
    end else if (start) begin
      m_mode[i] = 1;
    end
    if (sat) m_mode[i] = 2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear(0);
      m_clear(1);
    end else begin
      m_edge(0, 1'b1);
      m_edge(1, 1'b0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i);
    string s;
    s = (i == 0) ? "wrap" : "sat";
    chk({s, ".enable"},    int'(o_en[i]),   int'(m_mode[i] == 1));
    chk({s, ".status"},    int'(o_st[i]),   m_mode[i]);
    chk({s, ".tick"},      int'(o_tick[i]), m_tick[i]);
    chk({s, ".count"},     int'(o_cnt[i]),  m_cnt[i]);
    chk({s, ".overflow"},  int'(o_ovf[i]),  m_ovf[i]);
    chk({s, ".lap_valid"}, int'(o_lv[i]),   int'(mq[i].size() > 0));
    chk({s, ".lap_level"}, int'(o_ll[i]),   mq[i].size());
    chk({s, ".lap_drop"},  int'(o_drop[i]), m_drop[i]);
    if (mq[i].size() > 0)
      chk({s, ".lap_data"}, int'(o_ld[i]), mq[i][0]);
  endtask

  // Per-cycle comparison against the model, away from the edge.
  always @(negedge clk) begin
    if (en_cmp) begin
      cmp_inst(0);
      cmp_inst(1);
    end
  end

  task automatic step(input bit s, input bit t, input bit r,
                      input bit l, input bit rd);
    start  = s;
    stop   = t;
    reset  = r;
    lap    = l;
    lap_rd = rd;
    @(posedge clk);
    #2;
    start  = 0;
    stop   = 0;
    reset  = 0;
    lap    = 0;
    lap_rd = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk_rst(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".enable"},    int'(o_en[i]),   0);
      chk({tag, ".status"},    int'(o_st[i]),   0);
      chk({tag, ".count"},     int'(o_cnt[i]),  0);
      chk({tag, ".tick"},      int'(o_tick[i]), 0);
      chk({tag, ".overflow"},  int'(o_ovf[i]),  0);
      chk({tag, ".lap_valid"}, int'(o_lv[i]),   0);
      chk({tag, ".lap_level"}, int'(o_ll[i]),   0);
      chk({tag, ".lap_drop"},  int'(o_drop[i]), 0);
    end
  endtask

  initial begin
    rst_n  = 0;
    start  = 0;
    stop   = 0;
    reset  = 0;
    lap    = 0;
    lap_rd = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_rst("por");
    rst_n  = 1;
    en_cmp = 1;
    @(posedge clk);
    #2;

    // Run and pause.
    step(1, 0, 0, 0, 0);
    chk("run.status", int'(o_st[0]), 1);
    idle(12);
    chk("run.count12", int'(o_cnt[0]), 3);
    chk("run.tick12",  int'(o_tick[0]), 1);
    step(0, 1, 0, 0, 0);
    chk("pause.status", int'(o_st[0]), 2);
    chk("pause.count",  int'(o_cnt[0]), 3);
    idle(5);
    chk("pause.hold", int'(o_cnt[0]), 3);
    step(1, 0, 0, 0, 0);
    idle(2);
    chk("resume.count_early", int'(o_cnt[0]), 3);
    chk("resume.tick_early",  int'(o_tick[0]), 0);
    idle(1);
    chk("resume.count", int'(o_cnt[0]), 4);
    chk("resume.tick",  int'(o_tick[0]), 1);

    // Priority.
    step(1, 1, 0, 0, 0);
    chk("prio.stop_start", int'(o_st[0]), 2);
    step(1, 0, 1, 0, 0);
    chk("prio.reset_start", int'(o_st[0]), 0);
    chk("prio.reset_count", int'(o_cnt[0]), 0);

    // Laps.
    step(0, 0, 0, 1, 0);
    chk("lap.idle_ignored", int'(o_lv[0]), 0);
    step(1, 0, 0, 0, 0);
    idle(8);
    step(0, 0, 0, 1, 0);
    chk("lap.first_data", int'(o_ld[0]), 2);
    idle(11);
    step(0, 0, 0, 1, 0);
    idle(7);
    step(0, 0, 0, 1, 0);
    idle(7);
    step(0, 0, 0, 1, 0);
    idle(7);
    step(0, 0, 0, 1, 0);
    chk("lap.level_full", int'(o_ll[0]),   4);
    chk("lap.drop",       int'(o_drop[0]), 1);
    chk("lap.head2",      int'(o_ld[0]),   2);
    step(0, 0, 0, 1, 1);
    chk("lap.pushpop_level", int'(o_ll[0]), 4);
    chk("lap.head5",         int'(o_ld[0]), 5);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("lap.head7", int'(o_ld[0]), 7);
    step(0, 0, 0, 0, 1);
    chk("lap.head9",  int'(o_ld[0]), 9);
    chk("lap.level2", int'(o_ll[0]), 2);
    step(0, 0, 1, 1, 1);
    chk("lap.reset_valid", int'(o_lv[0]),   0);
    chk("lap.reset_level", int'(o_ll[0]),   0);
    chk("lap.reset_drop",  int'(o_drop[0]), 0);

    // Overflow: wrap vs saturate.
    step(1, 0, 0, 0, 0);
    idle(60);
    chk("ovf.wrap_max", int'(o_cnt[0]), 15);
    chk("ovf.sat_max",  int'(o_cnt[1]), 15);
    idle(4);
    chk("wrap.count",    int'(o_cnt[0]), 0);
    chk("wrap.overflow", int'(o_ovf[0]), 1);
    chk("wrap.status",   int'(o_st[0]),  1);
    chk("sat.count",     int'(o_cnt[1]), 15);
    chk("sat.overflow",  int'(o_ovf[1]), 1);
    chk("sat.status",    int'(o_st[1]),  2);
    chk("sat.enable",    int'(o_en[1]),  0);
    step(1, 0, 0, 0, 0);
    idle(3);
    chk("sat.rerun_status", int'(o_st[1]),  1);
    chk("sat.rerun_count",  int'(o_cnt[1]), 15);
    idle(1);
    chk("sat.repause_status", int'(o_st[1]),  2);
    chk("sat.repause_count",  int'(o_cnt[1]), 15);

    // Asynchronous reset mid-run with a lap held.
    step(0, 0, 0, 1, 0);
    chk("async.pre_valid", int'(o_lv[0]), 1);
    rst_n = 0;
    #1;
    chk_rst("async");
    #1;
    rst_n = 1;
    @(posedge clk);
    #2;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
